// File: rtl/ysyx_22040127_ifetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave): one outstanding read at a time.
interface ysyx_22040127_ifetch_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/ysyx_22040127_ifetch.sv
// Instruction fetch: owns the PC, one imem read in flight, single-entry buffer to decode.
// Define YSYX_22040127_IFETCH_EBREAK_EN to flag ebreak in bus bit 64.
module ysyx_22040127_ifetch #(
  parameter logic [31:0] RESET_PC       = 32'h8000_0000,
  parameter int          IF_TO_ID_WIDTH = 65
) (
  input  logic                      clk,
  input  logic                      rst,
  ysyx_22040127_ifetch_if.master    imem,
  input  logic                      id_allowin,
  output logic                      if_to_id_valid,
  output logic [IF_TO_ID_WIDTH-1:0] if_to_id_bus,
  input  logic                      id_branch_taken,
  input  logic [31:0]               id_branch_result,
  input  logic                      trap_redirect_valid,
  input  logic [31:0]               trap_redirect_pc,
  output logic                      if_busy
);

  typedef enum logic {S_REQ = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic [31:0] r_buf_pc;
  logic [31:0] r_buf_inst;
  logic        r_discard;
  logic        r_stale;
  logic        r_buf_valid;

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_req_fire;
  logic        w_fill;
  logic        w_ebreak;

  assign w_redirect  = trap_redirect_valid | id_branch_taken;
  assign w_target    = trap_redirect_valid ? trap_redirect_pc : id_branch_result;
  assign w_req_valid = ~rst & (r_state == S_REQ) & (~r_buf_valid | id_allowin);
  // A request already on the bus when a redirect hits keeps its address until
  // accepted; r_stale marks it so the response is dropped and pc is not bumped.
  assign w_req_addr  = r_stale ? r_req_addr : {r_pc[31:2], 2'b00};
  assign w_req_fire  = w_req_valid & imem.req_ready;
  assign w_fill      = (r_state == S_WAIT) & imem.resp_valid & ~r_discard & ~w_redirect;

  assign imem.req_valid = w_req_valid;
  assign imem.req_addr  = w_req_addr;
  assign if_to_id_valid = r_buf_valid;
  assign if_busy        = ~rst & ((r_state == S_WAIT) | (w_req_valid & ~imem.req_ready));
  assign if_to_id_bus   = IF_TO_ID_WIDTH'({w_ebreak, r_buf_inst, r_buf_pc});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC;
      r_req_addr  <= '0;
      r_discard   <= 1'b0;
      r_stale     <= 1'b0;
      r_buf_valid <= 1'b0;
      r_buf_pc    <= '0;
      r_buf_inst  <= '0;
    end else begin
      if (r_buf_valid & id_allowin) r_buf_valid <= 1'b0;
      case (r_state)
        S_REQ: begin
          if (w_req_fire) begin
            r_req_addr <= w_req_addr;
            r_state    <= S_WAIT;
            r_stale    <= 1'b0;
            r_discard  <= r_stale | w_redirect;
            if (!r_stale) r_pc <= r_pc + 32'd4;
          end else if (w_req_valid & w_redirect & ~r_stale) begin
            r_stale    <= 1'b1;
            r_req_addr <= w_req_addr;
          end
        end
        S_WAIT: begin
          if (imem.resp_valid) begin
            r_state   <= S_REQ;
            r_discard <= 1'b0;
            if (w_fill) begin
              r_buf_valid <= 1'b1;
              r_buf_inst  <= imem.resp_data;
              r_buf_pc    <= r_req_addr;
            end
          end else if (w_redirect) begin
            r_discard <= 1'b1;
          end
        end
      endcase
      // Redirect wins over any sequential pc update and flushes the buffer.
      if (w_redirect) begin
        r_pc        <= w_target;
        r_buf_valid <= 1'b0;
      end
    end
  end

`ifdef YSYX_22040127_IFETCH_EBREAK_EN
  logic r_ebreak;
  always_ff @(posedge clk) begin
    if (rst)         r_ebreak <= 1'b0;
    else if (w_fill) r_ebreak <= (imem.resp_data == 32'h0010_0073);
  end
  assign w_ebreak = r_ebreak;
`else
  assign w_ebreak = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22040127_ifetch.sv
// Randomized scoreboard bench for ysyx_22040127_ifetch: expected fetch stream is the
// sequential program order from RESET_PC, restarted at each redirect target.
module tb_ysyx_22040127_ifetch;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_allowin, if_to_id_valid, id_branch_taken, trap_redirect_valid, if_busy;
  logic [64:0] if_to_id_bus;
  logic [31:0] id_branch_result, trap_redirect_pc;

  always #5 clk = ~clk;

  ysyx_22040127_ifetch_if imem_if();

  ysyx_22040127_ifetch #(.RESET_PC(RESET_PC), .IF_TO_ID_WIDTH(65)) dut (
    .clk(clk), .rst(rst), .imem(imem_if),
    .id_allowin(id_allowin), .if_to_id_valid(if_to_id_valid), .if_to_id_bus(if_to_id_bus),
    .id_branch_taken(id_branch_taken), .id_branch_result(id_branch_result),
    .trap_redirect_valid(trap_redirect_valid), .trap_redirect_pc(trap_redirect_pc),
    .if_busy(if_busy)
  );

  int checks = 0, errors = 0, cyc = 0, xfers = 0;
  bit steady = 0;
  int lat_max = 1, ready_pct = 100;

  typedef struct { bit flush; int cyc; logic [31:0] pc; } exp_t;
  exp_t exp_q[$];
  logic [31:0] next_pc;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (a[5:2] == 4'd7) return EBREAK;
    return {a[15:0] ^ 16'h5a3c, a[31:16] ^ a[17:2]};
  endfunction

  function automatic logic exp_ebreak(logic [31:0] w);
`ifdef YSYX_22040127_IFETCH_EBREAK_EN
    return w == EBREAK;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(string name, logic [64:0] act, logic [64:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Instruction memory: accepts per ready_pct, answers after 1..lat_max cycles.
  bit          pend = 0;
  int          cnt = 0;
  logic [31:0] paddr = '0;
  initial begin
    imem_if.req_ready  = 1'b0;
    imem_if.resp_valid = 1'b0;
    imem_if.resp_data  = '0;
    forever begin
      @(posedge clk); #1;
      imem_if.resp_valid = 1'b0;
      if (rst) pend = 0;
      else if (pend) begin
        if (cnt <= 1) begin
          imem_if.resp_valid = 1'b1;
          imem_if.resp_data  = mem_word(paddr);
          pend = 0;
        end else cnt--;
      end
      imem_if.req_ready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      if (!rst) begin
        check("if_busy", if_busy,
              (pend | imem_if.resp_valid) | (imem_if.req_valid & ~imem_if.req_ready));
        if (imem_if.req_valid & imem_if.req_ready) begin
          check("one_outstanding", pend | imem_if.resp_valid, 0);
          check("req_align", imem_if.req_addr[1:0], 0);
          pend  = 1;
          paddr = imem_if.req_addr;
          cnt   = $urandom_range(lat_max, 1);
        end
      end
    end
  end

  // Monitor / scoreboard.
  bit          rst_d = 1, prev_hold = 0, prev_pend = 0;
  logic [64:0] prev_bus;
  logic [31:0] prev_addr;
  int          last_x = -1, rel_cyc = 0;
  initial begin
    exp_t        e;
    logic [31:0] w;
    int          idx;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (rst_d) begin
          check("rst_req_valid", imem_if.req_valid, 0);
          check("rst_if_valid", if_to_id_valid, 0);
          check("rst_bus", if_to_id_bus, 0);
          check("rst_busy", if_busy, 0);
        end
        prev_hold = 0; prev_pend = 0; last_x = -1;
      end else begin
        if (rst_d) begin
          rel_cyc = cyc;
          check("first_req_valid", imem_if.req_valid, 1);
          check("first_req_addr", imem_if.req_addr, RESET_PC);
        end
        if (prev_hold) begin
          check("hold_valid", if_to_id_valid, 1);
          check("hold_bus", if_to_id_bus, prev_bus);
        end
        if (prev_pend) begin
          check("req_hold_valid", imem_if.req_valid, 1);
          check("req_hold_addr", imem_if.req_addr, prev_addr);
        end
        if (if_to_id_valid && !id_allowin) check("no_req_when_full", imem_if.req_valid, 0);
        if (if_to_id_valid && id_allowin) begin
          xfers++;
          check("req_on_drain", imem_if.req_valid, 1);
          if (exp_q.size() == 0 || exp_q[0].flush) begin
            checks++; errors++;
            $display("FAIL xfer_unexpected actual pc %h required none (cycle %0d)",
                     if_to_id_bus[31:0], cyc);
          end else begin
            e = exp_q.pop_front();
            w = mem_word(e.pc);
            check("xfer_bus", if_to_id_bus, {exp_ebreak(w), w, e.pc});
          end
          if (steady) begin
            if (last_x < 0) check("first_xfer_lat", cyc - rel_cyc, 2);
            else            check("steady_gap", cyc - last_x, 2);
          end
          last_x = cyc;
        end
        prev_hold = if_to_id_valid & ~id_allowin & ~id_branch_taken & ~trap_redirect_valid;
        prev_bus  = if_to_id_bus;
        prev_pend = imem_if.req_valid & ~imem_if.req_ready;
        prev_addr = imem_if.req_addr;
      end
      // Entries queued before a redirect/reset marker of this cycle are wrong-path.
      idx = -1;
      foreach (exp_q[i]) if (exp_q[i].flush && exp_q[i].cyc <= cyc) idx = i;
      if (idx >= 0) exp_q = exp_q[idx+1:$];
      rst_d = rst;
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic refill();
    while (exp_q.size() < 16) begin
      exp_q.push_back('{flush: 1'b0, cyc: 0, pc: next_pc});
      next_pc += 32'd4;
    end
  endtask

  task automatic restart(logic [31:0] pc);
    exp_q.push_back('{flush: 1'b1, cyc: cyc, pc: 32'h0});
    next_pc = {pc[31:2], 2'b00};
    refill();
  endtask

  task automatic redirect(bit br, bit tr, logic [31:0] bt, logic [31:0] tt);
    id_branch_taken     = br;
    id_branch_result    = bt;
    trap_redirect_valid = tr;
    trap_redirect_pc    = tt;
    restart(tr ? tt : bt);
    step(); refill();
    id_branch_taken     = 1'b0;
    trap_redirect_valid = 1'b0;
  endtask

  task automatic wait_for(string name, bit want_wait);
    int n = 0;
    while (n < 50 && !(want_wait ? (if_busy && !imem_if.req_valid) : imem_if.req_valid)) begin
      step(); refill(); n++;
    end
    check(name, n < 50, 1);
  endtask

  initial begin
    logic [31:0] t;
    id_allowin = 1'b1; id_branch_taken = 1'b0; trap_redirect_valid = 1'b0;
    id_branch_result = '0; trap_redirect_pc = '0;
    next_pc = RESET_PC;
    refill();
    repeat (3) step();
    steady = 1; rst = 1'b0;
    repeat (30) begin step(); refill(); end
    steady = 0;

    // Stall decode for 5 cycles with a full buffer.
    begin
      int n = 0;
      while (n < 50 && !if_to_id_valid) begin step(); refill(); n++; end
      check("wait_buf_valid", n < 50, 1);
    end
    id_allowin = 1'b0;
    repeat (5) begin step(); refill(); end
    id_allowin = 1'b1;
    repeat (4) begin step(); refill(); end

    // Branch during WAIT, then trap and branch together.
    wait_for("wait_state_wait", 1);
    redirect(1, 0, 32'h8000_0100, 32'h0);
    repeat (6) begin step(); refill(); end
    redirect(1, 1, 32'h8000_0300, 32'h8000_0200);
    repeat (6) begin step(); refill(); end

    // Request held off for 3 cycles with a redirect on the first.
    ready_pct = 0;
    wait_for("wait_req_valid", 0);
    redirect(1, 0, 32'h8000_0400, 32'h0);
    repeat (2) begin step(); refill(); end
    ready_pct = 100;
    repeat (8) begin step(); refill(); end

    // Randomized traffic.
    ready_pct = 70; lat_max = 3;
    for (int k = 0; k < 2500; k++) begin
      id_allowin = ($urandom_range(9) < 7);
      if ($urandom_range(9) == 0) begin
        t = 32'h8000_0000 + ($urandom_range(1023) << 2);
        if ($urandom_range(7) == 0) t[1:0] = 2'($urandom_range(3));
        case ($urandom_range(2))
          0:       redirect(1, 0, t, 32'h0);
          1:       redirect(0, 1, 32'h0, t);
          default: redirect(1, 1, t ^ 32'h0000_0f00, t);
        endcase
      end else begin
        step(); refill();
      end
    end

    // Reset mid-traffic, then more random traffic.
    rst = 1'b1;
    restart(RESET_PC);
    repeat (2) step();
    rst = 1'b0;
    for (int k = 0; k < 300; k++) begin
      id_allowin = ($urandom_range(9) < 7);
      step(); refill();
    end

    id_allowin = 1'b1;
    repeat (10) begin step(); refill(); end
    check("xfer_count_min", xfers > 200, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_22040127_ifetch.md
# ysyx_22040127_ifetch

Instruction-fetch stage of the ysyx_22040127 five-stage RV64 pipeline. It owns the PC, issues one instruction-memory read at a time, buffers the returned word and presents it to decode over the `if_to_id` valid/allowin handshake. It redirects on a taken branch or jump from decode and on a trap or mret redirect from the back end, discarding any in-flight or buffered wrong-path fetch.

## Interface
Parameters:
- `RESET_PC`, default 32'h8000_0000: first fetch address after reset.
- `IF_TO_ID_WIDTH`, default 65: bus width; layout is `{ebreak[64], instruction[63:32], pc[31:0]}`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_req_addr` out 32: fetch address, word-aligned.
- `imem_resp_valid` in 1: read data valid, one pulse per accepted request.
- `imem_resp_data` in 32: instruction word.
- `id_allowin` in 1: decode can accept this cycle.
- `if_to_id_valid` out 1: buffer holds a valid instruction.
- `if_to_id_bus` out `IF_TO_ID_WIDTH`: buffered `{ebreak, inst, pc}`.
- `id_branch_taken` in 1: decode redirect request.
- `id_branch_result` in 32: decode redirect target.
- `trap_redirect_valid` in 1: back-end redirect (ecall, mret, interrupt).
- `trap_redirect_pc` in 32: back-end target (mtvec or mepc).
- `if_busy` out 1: a request is outstanding or pending; used by decode's jalr-stuck logic.

## Operation
- Registers: `pc` (next fetch address), `req_addr`, `state` ∈ {REQ, WAIT}, `discard`, `buf_valid`, `buf_pc`, `buf_inst`.
- REQ: `imem_req_valid=1` when `buf_valid==0` or the buffer drains this cycle (`if_to_id_valid && id_allowin`). On `imem_req_ready`: `req_addr<=pc`, `pc<=pc+4` (32-bit wrap), go to WAIT.
- WAIT: `imem_req_valid=0`. On `imem_resp_valid`:
  - If `discard==0`: `buf_valid<=1`, `buf_inst<=imem_resp_data`, `buf_pc<=req_addr`.
  - If `discard==1`: drop the data and clear `discard`.
  - In both cases, return to REQ.
- One outstanding request at most. A request is issued only when the buffer will be empty, so a response never finds the buffer full.
- Redirect: `redirect = trap_redirect_valid | id_branch_taken`. Target is `trap_redirect_pc` when `trap_redirect_valid`, else `id_branch_result`; trap has priority. On redirect:
  - `pc<=target` and `buf_valid<=0`.
  - If in WAIT without `imem_resp_valid`, or in REQ with the request accepted this cycle: `discard<=1`.
  - If in REQ and not yet accepted: keep `imem_req_valid` high and `imem_req_addr` unchanged. `discard` is set on acceptance.
  - Any `pc<=pc+4` in the same cycle is overridden by the target.
- A handshake coinciding with `id_branch_taken` counts as transferred; decode kills that slot itself.
- Redirect while `discard` is already set: update `pc` only.
- `if_busy = (state==WAIT) | (imem_req_valid & ~imem_req_ready)`.
- Target bit 1:0 nonzero: bits are forced to 0 on `imem_req_addr`.

## Timing
- Reset values: `imem_req_valid=0`, `if_to_id_valid=0`, `if_to_id_bus=0`, `pc=RESET_PC`, `state=REQ`, `discard=0`, `if_busy=0`.
- First request is asserted on the first cycle with `rst=0`.
- Single-cycle memory (response at t+1 after acceptance at t):
  - buffer valid at t+2;
  - next request asserted at t+2 if decode accepts;
  - steady state is 1 instruction per 2 cycles.
- Redirect at cycle r with an idle bus: request to the target is asserted at r+1.
- Redirect at cycle r while in WAIT: the target request is issued the cycle after the discarded response.
- `rst` asserted mid-transaction returns all state to reset values next edge. A late `imem_resp_valid` for a pre-reset request is ignored only if it arrives in REQ. Memory must itself be reset concurrently.

## Configuration
- `YSYX_22040127_IFETCH_EBREAK_EN` defined: bit 64 of the bus is `(buf_inst == 32'h0010_0073)`, registered with the buffer.
- Macro undefined: bit 64 is constant 0; ebreak is detected downstream only.

## Test plan
- Reset release, memory always ready with 1-cycle response -> requests at 8000_0000, 8000_0004, 8000_0008; each `if_to_id_bus[31:0]` matches its address; no gaps beyond 1 bubble.
- Hold `id_allowin=0` for 5 cycles with the buffer full -> `imem_req_valid` stays 0 and the bus stays stable; on release, the transfer occurs and the next request follows the same cycle.
- `id_branch_taken=1`, `id_branch_result=8000_0100` during WAIT -> the response is dropped (no `if_to_id_valid`); the next request address is 8000_0100.
- `trap_redirect_valid` (pc 8000_0200) and `id_branch_taken` (8000_0300) in the same cycle -> next fetch is 8000_0200.
- `imem_req_ready` low for 3 cycles with a redirect on cycle 1 -> address stays unchanged until accepted; that response is discarded; the following request goes to the target.
- With `YSYX_22040127_IFETCH_EBREAK_EN`, memory returns 0010_0073 -> bus bit 64 = 1; without the macro -> 0.
